fetch_unit: RTL and testbench
=============================

Name: fetch_unit

Overview:
- Instruction fetch front end; the consumer and controller of the ProgramCounter interface.
- Reads pc_out from ProgramCounter, issues single-outstanding reads to instruction memory, and queues {pc, instruction} pairs for decode.
- Drives pc_in / pc_write_enable back to ProgramCounter to stall, advance or redirect on a branch.
- PC contract: ProgramCounter loads pc_in when pc_write_enable=1; otherwise it increments pc_out by 1 each clk, wrapping 16'hFFFF -> 16'h0000.

Parameters:
ADDR_W, 16, PC / instruction-memory address width
INSTR_W, 16, instruction word width
QDEPTH, 4, fetch queue entries (power of 2, >=2)

Ports:
clk  input  1  system clock, rising edge
reset  input  1  asynchronous, active-low reset
pc_out  input  ADDR_W  current PC from ProgramCounter
pc_in  output  ADDR_W  value for ProgramCounter to load
pc_write_enable  output  1  1 = PC loads pc_in; 0 = PC increments
imem_req  output  1  read request, level
imem_addr  output  ADDR_W  read address, equal to pc_out
imem_ack  input  1  read data valid; counted only when imem_req=1 in the same cycle
imem_rdata  input  INSTR_W  read data, valid with imem_ack
branch_valid  input  1  redirect request, single-cycle pulse
branch_target  input  ADDR_W  redirect address
instr_valid  output  1  queue head valid
instr_data  output  INSTR_W  queue head instruction
instr_pc  output  ADDR_W  queue head PC
instr_ready  input  1  decode accepts head when instr_valid & instr_ready

Behaviour:
- FSM states are IDLE, FETCH and REDIR. While reset=0: state=IDLE, queue empty, instr_valid=0, imem_req=0, pc_write_enable=0, pc_in=0, instr_data=0, instr_pc=0.
- IDLE: first cycle after reset release. Hold the PC (pc_write_enable=1, pc_in=pc_out). No request. Next state is FETCH.
- FETCH:
  - imem_req = !(count==QDEPTH && !pop).
  - Without an accepted ack, hold the PC.
  - On an accepted ack: push {pc_out, imem_rdata} and drive pc_write_enable=0 so the PC increments. Gives one instruction per cycle when memory acks combinationally.
  - imem_req may drop before ack (queue full); any ack seen while imem_req=0 is ignored.
- REDIR: one bubble cycle. Hold the PC, no request, queue empty. Next state is FETCH.
- branch_valid in any non-reset state (highest priority):
  - pc_write_enable=1, pc_in=branch_target.
  - Flush the queue (count=0, pointers reset).
  - Discard any same-cycle ack.
  - Next state is REDIR.
  - If branch_valid arrives in IDLE, the redirect still wins.
- Queue: synchronous FIFO. Push and pop in the same cycle is legal when full or empty. The head is registered, so instr_valid rises the cycle after the push.
- A pop in the same cycle as branch_valid completes (decode owns that instruction). All other entries are flushed.
- PC wrap: a fetch at 16'hFFFF is queued with instr_pc=16'hFFFF; the next fetch uses 16'h0000. No special case.
- Asynchronous reset mid-fetch: outstanding request abandoned, queue cleared immediately, outputs forced to reset values without waiting for clk.
- Latency: branch_valid at edge N -> imem_req with imem_addr=target at N+2 -> earliest instr_valid at N+3 with a zero-wait ack.

Decomposition:
- Package fetch_pkg: state enum (IDLE, FETCH, REDIR), ADDR_W, INSTR_W, QDEPTH defaults, and a queue-entry struct {pc, instr}.
- Sub-module fetch_queue: parameterised FIFO with push, pop, flush, count, full, empty, plus the same clk / active-low asynchronous reset. fetch_unit instantiates one fetch_queue.

Test Plan:
- Reset release with pc_out=0, zero-wait ack, imem_rdata=16'hA000+addr, instr_ready=1 -> imem_addr sequence 0,1,2,3; instr_pc/instr_data pairs (0,A000), (1,A001)… one per cycle after a 2-cycle start.
- instr_ready=0 with continuous ack -> exactly 4 entries accepted; imem_req drops; pc_out frozen at 4 until instr_ready rises.
- branch_valid with branch_target=16'h1234 while 3 entries are queued and an ack is in the same cycle -> ack data discarded; instr_valid=0 within 1 cycle; next imem_addr=16'h1234 two cycles later; first instr_pc=16'h1234.
- Start fetch at pc=16'hFFFE -> instr_pc sequence FFFE, FFFF, 0000, 0001.
- Memory ack delayed 3 cycles per request -> pc_write_enable=1 with pc_in=pc_out during waits; one queue entry per ack; no duplicates.
- Assert reset (0) mid-stream with 2 entries queued -> instr_valid=0 and imem_req=0 immediately, before the next clk edge; after release, fetching restarts from pc_out.

Source files
------------

// File: rtl/fetch_pkg.sv
// -----------------------------------------------------------------------------
// fetch_pkg
//   Shared definitions for the instruction fetch front end:
//   - default widths and queue depth used as parameter defaults
//   - fetch FSM state encoding
//   - queue entry layout {pc, instr} as seen by decode
// -----------------------------------------------------------------------------
package fetch_pkg;

    localparam int DEF_ADDR_W  = 16;
    localparam int DEF_INSTR_W = 16;
    localparam int DEF_QDEPTH  = 4;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        FETCH = 2'd1,
        REDIR = 2'd2
    } fetch_state_t;

    typedef struct packed {
        logic [DEF_ADDR_W-1:0]  pc;
        logic [DEF_INSTR_W-1:0] instr;
    } fetch_entry_t;

endpackage

// File: rtl/fetch_queue.sv
// -----------------------------------------------------------------------------
// fetch_queue
//   Synchronous FIFO holding fetched {pc, instr} words for decode.
//   Push and pop in the same cycle are legal at any occupancy; a pop on an
//   empty queue and a push on a full queue without a pop are ignored.
//   flush empties the queue in one cycle and wins over push.
//
// Ports:
//   clk        rising-edge clock
//   reset      asynchronous, active-low reset
//   push       write push_data at the tail
//   push_data  entry to write
//   pop        retire the head entry
//   flush      drop all entries, rewind pointers
//   head       head entry, forced to zero when empty
//   full       DEPTH entries held
//   empty      no entries held
// -----------------------------------------------------------------------------
module fetch_queue #(
    parameter int DATA_W = 32,
    parameter int DEPTH  = 4
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              push,
    input  logic [DATA_W-1:0] push_data,
    input  logic              pop,
    input  logic              flush,
    output logic [DATA_W-1:0] head,
    output logic              full,
    output logic              empty
);

    localparam int PTR_W = $clog2(DEPTH);
    localparam logic [PTR_W:0] DEPTH_C = (PTR_W+1)'(DEPTH);

    logic [DATA_W-1:0] mem [DEPTH];
    logic [PTR_W-1:0]  wr_ptr;
    logic [PTR_W-1:0]  rd_ptr;
    logic [PTR_W:0]    count;
    logic              do_push;
    logic              do_pop;

    assign empty   = (count == '0);
    assign full    = (count == DEPTH_C);
    assign do_pop  = pop && !empty;
    assign do_push = push && (!full || do_pop);

    // NOTE: sequential state uses non-blocking assignments so every register
    // samples the pre-edge values regardless of statement order.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else if (flush) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (do_push) wr_ptr <= wr_ptr + 1'b1;
            if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
            case ({do_push, do_pop})
                2'b10:   count <= count + 1'b1;
                2'b01:   count <= count - 1'b1;
                default: count <= count;
            endcase
        end
    end

    // NOTE: the storage array has no reset; validity comes from count, and
    // head is masked while empty so stale words never reach decode.
    always_ff @(posedge clk) begin
        if (do_push && !flush) mem[wr_ptr] <= push_data;
    end

    assign head = empty ? '0 : mem[rd_ptr];

endmodule

// File: rtl/fetch_unit.sv
// -----------------------------------------------------------------------------
// fetch_unit
//   Instruction fetch front end. Controls the external ProgramCounter (which
//   loads pc_in when pc_write_enable=1 and otherwise increments), issues one
//   outstanding read at a time to instruction memory at pc_out, and queues
//   {pc, instr} pairs for decode. A branch redirect flushes the queue, loads
//   the target into the PC and inserts one bubble cycle (REDIR).
//
// Ports:
//   clk, reset                       clock, asynchronous active-low reset
//   pc_out / pc_in / pc_write_enable ProgramCounter read / load value / load
//   imem_req / imem_addr             level read request at pc_out
//   imem_ack / imem_rdata            read data, honoured only while imem_req
//   branch_valid / branch_target     single-cycle redirect
//   instr_valid / instr_data /
//   instr_pc / instr_ready           queue head to decode, valid/ready
// -----------------------------------------------------------------------------
module fetch_unit
    import fetch_pkg::*;
#(
    parameter int ADDR_W  = DEF_ADDR_W,
    parameter int INSTR_W = DEF_INSTR_W,
    parameter int QDEPTH  = DEF_QDEPTH
) (
    input  logic               clk,
    input  logic               reset,
    input  logic [ADDR_W-1:0]  pc_out,
    output logic [ADDR_W-1:0]  pc_in,
    output logic               pc_write_enable,
    output logic               imem_req,
    output logic [ADDR_W-1:0]  imem_addr,
    input  logic               imem_ack,
    input  logic [INSTR_W-1:0] imem_rdata,
    input  logic               branch_valid,
    input  logic [ADDR_W-1:0]  branch_target,
    output logic               instr_valid,
    output logic [INSTR_W-1:0] instr_data,
    output logic [ADDR_W-1:0]  instr_pc,
    input  logic               instr_ready
);

    fetch_state_t state;
    fetch_state_t state_next;

    logic                      q_push;
    logic                      q_pop;
    logic                      q_flush;
    logic                      q_full;
    logic                      q_empty;
    logic [ADDR_W+INSTR_W-1:0] q_head;

    assign imem_addr   = pc_out;
    assign instr_valid = !q_empty;
    // A pop alongside a branch still completes: decode owns that entry.
    assign q_pop       = instr_valid && instr_ready;
    assign {instr_pc, instr_data} = q_head;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) state <= IDLE;
        else        state <= state_next;
    end

    // NOTE: every output of this block is given a default first, so no path
    // leaves a signal unassigned and no latch is inferred.
    always_comb begin
        state_next      = state;
        pc_write_enable = 1'b1;
        pc_in           = pc_out;
        imem_req        = 1'b0;
        q_push          = 1'b0;
        q_flush         = 1'b0;

        case (state)
            IDLE:  state_next = FETCH;
            FETCH: begin
                // Only stop requesting when full and nothing leaves this cycle.
                imem_req = !(q_full && !q_pop);
                if (imem_req && imem_ack) begin
                    q_push          = 1'b1;
                    pc_write_enable = 1'b0;
                end
            end
            REDIR: state_next = FETCH;
            default: state_next = IDLE;
        endcase

        // Redirect overrides everything, including a same-cycle ack.
        if (branch_valid) begin
            pc_write_enable = 1'b1;
            pc_in           = branch_target;
            q_push          = 1'b0;
            q_flush         = 1'b1;
            state_next      = REDIR;
        end

        // Outputs fall to their idle values as soon as reset asserts,
        // without waiting for the state register to see a clock.
        if (!reset) begin
            pc_write_enable = 1'b0;
            pc_in           = '0;
            imem_req        = 1'b0;
            q_push          = 1'b0;
            q_flush         = 1'b0;
        end
    end

    fetch_queue #(
        .DATA_W (ADDR_W + INSTR_W),
        .DEPTH  (QDEPTH)
    ) u_queue (
        .clk       (clk),
        .reset     (reset),
        .push      (q_push),
        .push_data ({pc_out, imem_rdata}),
        .pop       (q_pop),
        .flush     (q_flush),
        .head      (q_head),
        .full      (q_full),
        .empty     (q_empty)
    );

endmodule

// File: tb/tb_fetch_unit.sv
// -----------------------------------------------------------------------------
// tb_fetch_unit
//   Self-checking bench for fetch_unit. Surrounds the DUT with a ProgramCounter
//   model and an instruction memory whose word at address a is a + 16'hA000.
//   The reference model is the instruction stream decode should see: a
//   contiguous run of addresses restarting at each branch target, plus an
//   occupancy count of accepted-but-not-retired fetches.
// -----------------------------------------------------------------------------
module tb_fetch_unit;
    import fetch_pkg::*;

    localparam int AW = DEF_ADDR_W;
    localparam int IW = DEF_INSTR_W;
    localparam int QD = DEF_QDEPTH;

    logic          clk = 1'b0;
    logic          reset = 1'b0;
    logic [AW-1:0] pc_out = '0;
    logic [AW-1:0] pc_in;
    logic          pc_write_enable;
    logic          imem_req;
    logic [AW-1:0] imem_addr;
    logic          imem_ack;
    logic [IW-1:0] imem_rdata;
    logic          branch_valid = 1'b0;
    logic [AW-1:0] branch_target = '0;
    logic          instr_valid;
    logic [IW-1:0] instr_data;
    logic [AW-1:0] instr_pc;
    logic          instr_ready = 1'b0;

    fetch_unit dut (
        .clk             (clk),
        .reset           (reset),
        .pc_out          (pc_out),
        .pc_in           (pc_in),
        .pc_write_enable (pc_write_enable),
        .imem_req        (imem_req),
        .imem_addr       (imem_addr),
        .imem_ack        (imem_ack),
        .imem_rdata      (imem_rdata),
        .branch_valid    (branch_valid),
        .branch_target   (branch_target),
        .instr_valid     (instr_valid),
        .instr_data      (instr_data),
        .instr_pc        (instr_pc),
        .instr_ready     (instr_ready)
    );

    always #5 clk = ~clk;

    function automatic logic [IW-1:0] mem_word(input logic [AW-1:0] a);
        return a + 16'hA000;
    endfunction

    // ProgramCounter model; pc_hold pins it to pc_start while the bench sets up.
    logic          pc_hold = 1'b1;
    logic [AW-1:0] pc_start = '0;
    always @(posedge clk) begin
        if (pc_hold)              pc_out <= pc_start;
        else if (pc_write_enable) pc_out <= pc_in;
        else                      pc_out <= pc_out + 1'b1;
    end

    // Instruction memory: acks after cur_delay waiting cycles; spur raises a
    // stray ack while no request is pending.
    int   base_delay = 0;
    logic rand_delay = 1'b0;
    int   rnd_delay  = 0;
    int   wait_cnt   = 0;
    logic spur       = 1'b0;
    int   cur_delay;
    assign cur_delay = rand_delay ? rnd_delay : base_delay;

    always_comb begin
        imem_rdata = mem_word(imem_addr);
        imem_ack   = (imem_req && (wait_cnt >= cur_delay)) || (spur && !imem_req);
    end

    always @(posedge clk) begin
        if (!reset || !imem_req) begin
            wait_cnt <= 0;
        end else if (imem_ack) begin
            wait_cnt  <= 0;
            rnd_delay <= int'($urandom_range(0, 2));
        end else begin
            wait_cnt <= wait_cnt + 1;
        end
    end

    // Reference model state and counters.
    int            vectors     = 0;
    int            miscompares = 0;
    int            occ         = 0;
    int            acc_n       = 0;
    logic [AW-1:0] exp_pc      = '0;
    fetch_entry_t  seen[$];

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    function automatic logic [AW-1:0] seen_pc(input int k);
        return (seen.size() > k) ? seen[k].pc : 'x;
    endfunction

    // Evaluates the cycle about to be clocked; called mid-cycle.
    task automatic monitor();
        logic pop;
        logic acc;
        if (reset) begin
            pop = instr_valid && instr_ready;
            acc = imem_req && imem_ack && !branch_valid;
            check("valid_vs_occupancy", instr_valid, occ > 0);
            if (pop) begin
                check("head_pc", instr_pc, exp_pc);
                check("head_data", instr_data, mem_word(exp_pc));
                seen.push_back('{pc: instr_pc, instr: instr_data});
                exp_pc = exp_pc + 1'b1;
                occ--;
            end
            check("pc_write_enable", pc_write_enable, !acc);
            if (branch_valid)
                check("pc_in_target", pc_in, branch_target);
            else if (!acc)
                check("pc_in_hold", pc_in, pc_out);
            if (acc) begin
                check("imem_addr", imem_addr, pc_out);
                occ++;
                acc_n++;
            end
            if (branch_valid) begin
                occ    = 0;
                exp_pc = branch_target;
            end
            check("occupancy_bound", occ <= QD, 1'b1);
        end
    endtask

    task automatic cycle();
        #1;
        monitor();
        @(negedge clk);
    endtask

    // Holds reset for two edges with the PC pinned, then releases at a negedge.
    task automatic do_reset(input logic [AW-1:0] start);
        reset        = 1'b0;
        pc_hold      = 1'b1;
        pc_start     = start;
        branch_valid = 1'b0;
        instr_ready  = 1'b0;
        spur         = 1'b0;
        repeat (2) @(negedge clk);
        reset   = 1'b1;
        pc_hold = 1'b0;
        occ     = 0;
        acc_n   = 0;
        exp_pc  = start;
        seen.delete();
    endtask

    logic [AW-1:0] wrap_exp [4];
    logic [AW-1:0] restart_pc;

    initial begin
        // Reset values, with a branch pulse that must be ignored.
        branch_valid  = 1'b1;
        branch_target = 16'h5555;
        spur          = 1'b1;
        repeat (2) @(negedge clk);
        #1;
        check("rst_instr_valid", instr_valid, 1'b0);
        check("rst_imem_req", imem_req, 1'b0);
        check("rst_pc_we", pc_write_enable, 1'b0);
        check("rst_pc_in", pc_in, '0);
        check("rst_instr_data", instr_data, '0);
        check("rst_instr_pc", instr_pc, '0);

        // Zero-wait streaming from address 0.
        do_reset(16'h0000);
        instr_ready = 1'b1;
        #1 check("start_idle_req", imem_req, 1'b0);
        cycle();
        for (int i = 0; i < 4; i++) begin
            #1 check("start_addr", imem_addr, i);
            cycle();
        end
        check("start_pops", seen.size(), 3);
        check("start_first_pc", seen_pc(0), 16'h0000);

        // Back-pressure: exactly QD fetches, request drops, PC frozen.
        do_reset(16'h0000);
        spur = 1'b1;
        repeat (10) cycle();
        #1;
        check("bp_req_drop", imem_req, 1'b0);
        check("bp_pc_frozen", pc_out, 16'h0004);
        check("bp_accepted", acc_n, QD);
        check("bp_head_pc", instr_pc, 16'h0000);
        spur        = 1'b0;
        instr_ready = 1'b1;
        repeat (8) cycle();
        check("bp_drain", seen.size(), 8);

        // Branch with 3 queued and a same-cycle ack.
        do_reset(16'h0000);
        repeat (4) cycle();
        check("br_occ_before", occ, 3);
        branch_valid  = 1'b1;
        branch_target = 16'h1234;
        #1;
        check("br_ack_present", imem_ack, 1'b1);
        check("br_pc_in", pc_in, 16'h1234);
        cycle();
        branch_valid = 1'b0;
        #1;
        check("br_valid_drop", instr_valid, 1'b0);
        check("br_bubble_req", imem_req, 1'b0);
        cycle();
        #1;
        check("br_req", imem_req, 1'b1);
        check("br_addr", imem_addr, 16'h1234);
        instr_ready = 1'b1;
        for (int i = 0; i < 8 && !instr_valid; i++) cycle();
        check("br_first_valid", instr_valid, 1'b1);
        check("br_first_pc", instr_pc, 16'h1234);
        cycle();

        // Branch arriving in IDLE still redirects.
        do_reset(16'h0040);
        branch_valid  = 1'b1;
        branch_target = 16'h0BEE;
        #1 check("idle_br_pc_in", pc_in, 16'h0BEE);
        cycle();
        branch_valid = 1'b0;
        instr_ready  = 1'b1;
        repeat (6) cycle();
        check("idle_br_first_pc", seen_pc(0), 16'h0BEE);

        // PC wrap.
        do_reset(16'hFFFE);
        instr_ready = 1'b1;
        repeat (7) cycle();
        wrap_exp = '{16'hFFFE, 16'hFFFF, 16'h0000, 16'h0001};
        for (int k = 0; k < 4; k++) check("wrap_pc", seen_pc(k), wrap_exp[k]);

        // Three wait cycles per request.
        do_reset(16'h0100);
        base_delay  = 3;
        instr_ready = 1'b1;
        repeat (20) cycle();
        check("slow_accepts", acc_n, 4);
        check("slow_pops", seen.size(), 4);
        base_delay = 0;

        // Asynchronous reset mid-stream with 2 entries queued.
        do_reset(16'h0000);
        repeat (3) cycle();
        check("mid_occ", occ, 2);
        #2 reset = 1'b0;
        #1;
        check("mid_instr_valid", instr_valid, 1'b0);
        check("mid_imem_req", imem_req, 1'b0);
        check("mid_pc_we", pc_write_enable, 1'b0);
        check("mid_instr_pc", instr_pc, '0);
        repeat (2) @(negedge clk);
        reset      = 1'b1;
        restart_pc = pc_out;
        occ        = 0;
        acc_n      = 0;
        exp_pc     = restart_pc;
        seen.delete();
        instr_ready = 1'b1;
        repeat (6) cycle();
        check("mid_restart_pops", seen.size(), 4);
        check("mid_restart_pc", seen_pc(0), restart_pc);

        // Randomised traffic: ready, branches, ack latency, stray acks.
        do_reset(AW'($urandom));
        rand_delay = 1'b1;
        for (int i = 0; i < 600; i++) begin
            instr_ready   = ($urandom_range(0, 3) != 0);
            branch_valid  = ($urandom_range(0, 19) == 0);
            branch_target = AW'($urandom);
            spur          = $urandom_range(0, 1) != 0;
            cycle();
        end
        branch_valid = 1'b0;
        check("rand_progress", acc_n > 50, 1'b1);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
